clique_checker: RTL and testbench

Sequential verifier for candidate cliques produced by the clique-finder datapath. It accepts a candidate vertex mask over a valid/ready handshake and latches the adjacency matrix at acceptance. It then walks every vertex pair, one pair per cycle, and returns a result over a second valid/ready handshake. The result carries the vertex count, the all-edges-present flag, the final is-clique flag against target size K, and the first missing edge found.

---
 rtl/clique_checker.sv | 118 +++++++++++
 tb/tb_clique_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clique_checker.sv
// Sequential clique verifier: latches a candidate mask and adjacency matrix,
// walks every vertex pair (one per cycle) and reports size, edge and clique status.
module clique_checker #(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0][N-1:0]        adj_matrix,
    input  logic                       cand_valid,
    output logic                       cand_ready,
    input  logic [N-1:0]               cand_mask,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N+1)-1:0]     res_size,
    output logic                       res_edge_ok,
    output logic                       res_is_clique,
    output logic [$clog2(N)-1:0]       res_bad_i,
    output logic [$clog2(N)-1:0]       res_bad_j
);

    localparam int SW = $clog2(N+1);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [N-1:0]          r_mask;
    logic [N-1:0][N-1:0]   r_adj;
    logic [IW-1:0]         r_i;
    logic [IW-1:0]         r_j;
    logic [SW-1:0]         r_size;
    logic                  r_edge_ok;
    logic [IW-1:0]         r_bad_i;
    logic [IW-1:0]         r_bad_j;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_fail;
    logic                  w_row_end;

    function automatic logic [SW-1:0] f_popcount(input logic [N-1:0] m);
        logic [SW-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) c = c + SW'(m[k]);
        return c;
    endfunction

    assign w_accept  = (r_state == IDLE) && cand_valid;
    assign w_row_end = (r_j == IW'(N-1));
    assign w_last    = (r_i == IW'(N-2)) && w_row_end;
    assign w_fail    = r_mask[r_i] && r_mask[r_j] && !r_adj[r_i][r_j];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cand_valid) w_next = CHECK;
            CHECK:   if (w_last)     w_next = DONE;
            DONE:    if (res_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cand_ready = (r_state == IDLE);
        res_valid  = (r_state == DONE);
    end

    // Result registers are cleared on reset so an aborted check leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask    <= '0;
            r_adj     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_size    <= '0;
            r_edge_ok <= 1'b0;
            r_bad_i   <= '0;
            r_bad_j   <= '0;
        end else if (w_accept) begin
            r_mask    <= cand_mask;
            r_adj     <= adj_matrix;
            r_size    <= f_popcount(cand_mask);
            r_edge_ok <= 1'b1;
            r_bad_i   <= '0;
            r_bad_j   <= '0;
            r_i       <= '0;
            r_j       <= IW'(1);
        end else if (r_state == CHECK) begin
            // Only the first missing edge is recorded; the walk never exits early.
            if (w_fail && r_edge_ok) begin
                r_edge_ok <= 1'b0;
                r_bad_i   <= r_i;
                r_bad_j   <= r_j;
            end
            if (!w_last) begin
                if (w_row_end) begin
                    r_i <= r_i + IW'(1);
                    r_j <= r_i + IW'(2);
                end else begin
                    r_j <= r_j + IW'(1);
                end
            end
        end
    end

    assign res_size      = r_size;
    assign res_edge_ok   = r_edge_ok;
    assign res_is_clique = r_edge_ok && (r_size == SW'(K));
    assign res_bad_i     = r_bad_i;
    assign res_bad_j     = r_bad_j;

endmodule

// File: tb/tb_clique_checker.sv
// Scoreboard bench for clique_checker (N=3, K=3) with directed vectors.
module tb_clique_checker;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][2:0]  adj_matrix;
    logic             cand_valid;
    logic             cand_ready;
    logic [2:0]       cand_mask;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_size;
    logic             res_edge_ok;
    logic             res_is_clique;
    logic [1:0]       res_bad_i;
    logic [1:0]       res_bad_j;

    typedef struct packed {
        logic [1:0] size;
        logic       edge_ok;
        logic       is_clique;
        logic [1:0] bad_i;
        logic [1:0] bad_j;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [2:0][2:0] full_adj;
    logic [2:0][2:0] miss12_adj;
    logic [2:0][2:0] only01_adj;

    clique_checker #(.N(3), .K(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .adj_matrix    (adj_matrix),
        .cand_valid    (cand_valid),
        .cand_ready    (cand_ready),
        .cand_mask     (cand_mask),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_size      (res_size),
        .res_edge_ok   (res_edge_ok),
        .res_is_clique (res_is_clique),
        .res_bad_i     (res_bad_i),
        .res_bad_j     (res_bad_j)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every completed result handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(res_size), 32'hdead);
            end else begin
                exp_t e;
                exp_t a;
                e = q.pop_front();
                a = '{res_size, res_edge_ok, res_is_clique, res_bad_i, res_bad_j};
                chk("result", 32'(a), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one candidate, optionally scrambling inputs after acceptance, and check latency.
    task automatic send(input logic [2:0] m, input logic [2:0][2:0] a, input exp_t e,
                        input bit scramble);
        int n;
        n = 0;
        while (!cand_ready && n < 50) begin tick(); n++; end
        chk("cand_ready_wait", 32'(cand_ready), 32'd1);
        cand_mask  = m;
        adj_matrix = a;
        cand_valid = 1'b1;
        q.push_back(e);
        tick();
        cand_valid = 1'b0;
        if (scramble) begin
            cand_mask  = '0;
            adj_matrix = '0;
        end
        n = 1;
        while (!res_valid && n < 20) begin tick(); n++; end
        chk("latency", 32'(n), 32'd4);
    endtask

    initial begin
        exp_t snap;
        full_adj   = '0;
        full_adj[0][1] = 1'b1; full_adj[0][2] = 1'b1; full_adj[1][2] = 1'b1;
        miss12_adj = '0;
        miss12_adj[0][1] = 1'b1; miss12_adj[0][2] = 1'b1; miss12_adj[2][1] = 1'b1;
        only01_adj = '0;
        only01_adj[0][1] = 1'b1;

        rst = 1'b1; cand_valid = 1'b0; cand_mask = '0; adj_matrix = '0; res_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_res_valid",  32'(res_valid),     32'd0);
        chk("rst_cand_ready", 32'(cand_ready),    32'd1);
        chk("rst_size",       32'(res_size),      32'd0);
        chk("rst_edge_ok",    32'(res_edge_ok),   32'd0);
        chk("rst_is_clique",  32'(res_is_clique), 32'd0);
        chk("rst_bad",        32'({res_bad_i, res_bad_j}), 32'd0);

        send(3'b111, full_adj,   '{2'd3, 1'b1, 1'b1, 2'd0, 2'd0}, 1'b0);
        send(3'b111, miss12_adj, '{2'd3, 1'b0, 1'b0, 2'd1, 2'd2}, 1'b0);
        send(3'b011, only01_adj, '{2'd2, 1'b1, 1'b0, 2'd0, 2'd0}, 1'b0);
        send(3'b000, only01_adj, '{2'd0, 1'b1, 1'b0, 2'd0, 2'd0}, 1'b0);
        send(3'b101, full_adj,   '{2'd2, 1'b1, 1'b0, 2'd0, 2'd0}, 1'b0);
        send(3'b110, only01_adj, '{2'd2, 1'b0, 1'b0, 2'd1, 2'd2}, 1'b0);
        send(3'b111, only01_adj, '{2'd3, 1'b0, 1'b0, 2'd0, 2'd2}, 1'b0);
        send(3'b100, 9'h000,     '{2'd1, 1'b1, 1'b0, 2'd0, 2'd0}, 1'b0);
        tick();

        // Backpressure: result must hold while res_ready is low.
        res_ready = 1'b0;
        send(3'b111, full_adj, '{2'd3, 1'b1, 1'b1, 2'd0, 2'd0}, 1'b0);
        snap = '{res_size, res_edge_ok, res_is_clique, res_bad_i, res_bad_j};
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid",      32'(res_valid),  32'd1);
            chk("bp_cand_ready", 32'(cand_ready), 32'd0);
            chk("bp_hold", 32'({res_size, res_edge_ok, res_is_clique, res_bad_i, res_bad_j}),
                32'(snap));
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(res_valid),  32'd0);
        chk("bp_release_ready", 32'(cand_ready), 32'd1);

        // Input isolation: inputs cleared right after acceptance.
        send(3'b111, full_adj, '{2'd3, 1'b1, 1'b1, 2'd0, 2'd0}, 1'b1);
        tick();

        // Reset during the second CHECK cycle discards the candidate.
        cand_mask = 3'b111; adj_matrix = miss12_adj; cand_valid = 1'b1;
        tick();
        cand_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid",     32'(res_valid),     32'd0);
        chk("abort_ready",     32'(cand_ready),    32'd1);
        chk("abort_size",      32'(res_size),      32'd0);
        chk("abort_edge_ok",   32'(res_edge_ok),   32'd0);
        chk("abort_is_clique", 32'(res_is_clique), 32'd0);
        chk("abort_bad",       32'({res_bad_i, res_bad_j}), 32'd0);
        for (int c = 0; c < 10; c++) tick();
        chk("abort_no_result", 32'(res_valid), 32'd0);

        send(3'b011, full_adj, '{2'd2, 1'b1, 1'b0, 2'd0, 2'd0}, 1'b0);
        tick(); tick();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
